// File: rtl/bpu_pkg.sv
// Shared constants and helpers for the branch predict/resolve unit.
package bpu_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  // Number of index bits needed to address 'entries' counters (ceil log2).
  function automatic int unsigned idx_width(input int unsigned entries);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 9; i++) begin
      if ((32'd1 << i) < entries) w = i + 1;
    end
    return w;
  endfunction

  // Weakly-not-taken: MSB clear, all lower bits set (0 for a 1-bit counter).
  function automatic logic [3:0] wnt_value(input int unsigned ctr_w);
    return 4'((32'd1 << (ctr_w - 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predict_resolve_if.sv
// IF lookup and EX resolve signals of the branch unit; stat outputs exist with BPU_STATS_EN.
interface branch_predict_resolve_if #(
  parameter int unsigned PC_W = 32
);
  logic [PC_W-1:0] if_pc;
  logic            if_pred_taken;
  logic            ex_valid;
  logic            ex_branch;
  logic [PC_W-1:0] ex_pc;
  logic [2:0]      ex_b_control;
  logic            ex_zflag;
  logic            ex_oflag;
  logic            ex_cflag;
  logic            ex_nflag;
  logic            ex_pred_taken;
  logic            ex_taken;
  logic            mispredict;
  logic            flush_q;
  logic            illegal_bcond;
`ifdef BPU_STATS_EN
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispred;
  logic [15:0]     stat_illegal;
`endif

  modport master (
    output if_pc, ex_valid, ex_branch, ex_pc, ex_b_control,
           ex_zflag, ex_oflag, ex_cflag, ex_nflag, ex_pred_taken,
`ifdef BPU_STATS_EN
    input  stat_branches, stat_mispred, stat_illegal,
`endif
    input  if_pred_taken, ex_taken, mispredict, flush_q, illegal_bcond
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_pc, ex_b_control,
           ex_zflag, ex_oflag, ex_cflag, ex_nflag, ex_pred_taken,
`ifdef BPU_STATS_EN
    output stat_branches, stat_mispred, stat_illegal,
`endif
    output if_pred_taken, ex_taken, mispredict, flush_q, illegal_bcond
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up/down counter, reset to weakly-not-taken; one instance per BHT entry.
module sat_counter
  import bpu_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [CTR_W-1:0] value
);

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(wnt_value(CTR_W));

  // Holds at the rails instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= CTR_RST;
    end else if (en) begin
      if (inc && (value != CTR_MAX)) begin
        value <= value + CTR_W'(1);
      end else if (!inc && dec && (value != '0)) begin
        value <= value - CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: BHT prediction in IF, condition resolution, mispredict and training in EX.
// Optional counters under the BPU_STATS_EN macro.
module branch_predict_resolve
  import bpu_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned CTR_W       = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  branch_predict_resolve_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(BHT_ENTRIES);

  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [CTR_W-1:0] ctr [BHT_ENTRIES];
  logic             is_branch;
  logic             taken;
  logic             illegal;
  logic             train;
  logic             mispred;
  logic             unused_pc_bits;

  assign if_idx = bus.if_pc[IDX_W+1:2];
  assign ex_idx = bus.ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{bus.if_pc[PC_W-1:IDX_W+2], bus.if_pc[1:0],
                            bus.ex_pc[PC_W-1:IDX_W+2], bus.ex_pc[1:0]};

  // Lookup reads the registered table, so a same-cycle write is not visible.
  assign bus.if_pred_taken = ctr[if_idx][CTR_W-1];

  assign is_branch = bus.ex_valid & bus.ex_branch;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    if (is_branch) begin
      case (bus.ex_b_control)
        BEQ:     taken = bus.ex_zflag;
        BNE:     taken = !bus.ex_zflag;
        BLT:     taken = bus.ex_nflag != bus.ex_oflag;
        BGE:     taken = bus.ex_nflag == bus.ex_oflag;
        BLTU:    taken = !bus.ex_cflag;
        BGEU:    taken = bus.ex_cflag;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign train   = is_branch & !illegal;
  assign mispred = train & (taken != bus.ex_pred_taken);

  assign bus.ex_taken      = taken;
  assign bus.illegal_bcond = illegal;
  assign bus.mispredict    = mispred;

  for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
    sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (train && (ex_idx == IDX_W'(i))),
      .inc   (taken),
      .dec   (!taken),
      .value (ctr[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.flush_q <= 1'b0;
    end else begin
      bus.flush_q <= mispred;
    end
  end

`ifdef BPU_STATS_EN
  // Event counters wrap naturally at their width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.stat_branches <= '0;
      bus.stat_mispred  <= '0;
      bus.stat_illegal  <= '0;
    end else begin
      if (train)   bus.stat_branches <= bus.stat_branches + 32'(1);
      if (mispred) bus.stat_mispred  <= bus.stat_mispred + 32'(1);
      if (illegal) bus.stat_illegal  <= bus.stat_illegal + 16'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: vector table, corner sequences, randomized run vs a reference model.
module tb_branch_predict_resolve;
  import bpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predict_resolve_if #(.PC_W(32)) bus ();

  branch_predict_resolve #(.PC_W(32), .BHT_ENTRIES(16), .CTR_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: counters as plain integers 0..3, last-cycle mispredict, event counts.
  int          bht [16];
  bit          prev_mis;
  int unsigned m_br, m_mis, m_ill;

  typedef struct {
    logic       v;
    logic       br;
    logic [2:0] f3;
    logic       z, o, c, n;
    logic       pt;
    logic       et;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'hf);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) bht[i] = 1;
    prev_mis = 1'b0;
    m_br = 0; m_mis = 0; m_ill = 0;
  endtask

  task automatic drive(input logic v, input logic br, input logic [2:0] f3,
                       input logic z, input logic o, input logic c, input logic n,
                       input logic pt, input logic [31:0] pc, input logic [31:0] ifpc);
    bus.ex_valid      = v;
    bus.ex_branch     = br;
    bus.ex_b_control  = f3;
    bus.ex_zflag      = z;
    bus.ex_oflag      = o;
    bus.ex_cflag      = c;
    bus.ex_nflag      = n;
    bus.ex_pred_taken = pt;
    bus.ex_pc         = pc;
    bus.if_pc         = ifpc;
  endtask

  // One cycle: drive after the falling edge, check, then advance the model at the rising edge.
  task automatic apply(input string tag, input logic v, input logic br, input logic [2:0] f3,
                       input logic z, input logic o, input logic c, input logic n,
                       input logic pt, input logic [31:0] pc, input logic [31:0] ifpc,
                       input logic et);
    bit ill, mis, trn;
    @(negedge clk);
    drive(v, br, f3, z, o, c, n, pt, pc, ifpc);
    #1;
    ill = v && br && (f3 == 3'b010 || f3 == 3'b011);
    trn = v && br && !ill;
    mis = trn && (et != pt);
    chk({tag, "_pred"},    32'(bus.if_pred_taken), 32'(bht[midx(ifpc)] >= 2));
    chk({tag, "_taken"},   32'(bus.ex_taken),      32'(et));
    chk({tag, "_mispred"}, 32'(bus.mispredict),    32'(mis));
    chk({tag, "_illegal"}, 32'(bus.illegal_bcond), 32'(ill));
    chk({tag, "_flush_q"}, 32'(bus.flush_q),       32'(prev_mis));
`ifdef BPU_STATS_EN
    chk({tag, "_stat_br"},  bus.stat_branches,     m_br);
    chk({tag, "_stat_mis"}, bus.stat_mispred,      m_mis);
    chk({tag, "_stat_ill"}, 32'(bus.stat_illegal), m_ill & 32'hffff);
`endif
    @(posedge clk);
    if (trn) begin
      if (et) bht[midx(pc)] = (bht[midx(pc)] == 3) ? 3 : bht[midx(pc)] + 1;
      else    bht[midx(pc)] = (bht[midx(pc)] == 0) ? 0 : bht[midx(pc)] - 1;
    end
    prev_mis = mis;
    m_br  += 32'(trn);
    m_mis += 32'(mis);
    m_ill += 32'(ill);
  endtask

  task automatic idle(input string tag, input logic [31:0] ifpc);
    apply(tag, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, ifpc, 1'b0);
  endtask

  initial begin
    //            v   br  f3      z  o  c  n  pt et
    tbl[0]  = '{1'b1,1'b1,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1};  // BEQ Z=1
    tbl[1]  = '{1'b1,1'b1,3'b000,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};  // BEQ Z=0
    tbl[2]  = '{1'b1,1'b1,3'b001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};  // BNE Z=1
    tbl[3]  = '{1'b1,1'b1,3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};  // BNE Z=0
    tbl[4]  = '{1'b1,1'b1,3'b100,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};  // BLT N=1 O=0
    tbl[5]  = '{1'b1,1'b1,3'b100,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0};  // BLT N=1 O=1
    tbl[6]  = '{1'b1,1'b1,3'b101,1'b0,1'b1,1'b0,1'b1,1'b0,1'b1};  // BGE N=1 O=1
    tbl[7]  = '{1'b1,1'b1,3'b101,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0};  // BGE N=1 O=0
    tbl[8]  = '{1'b1,1'b1,3'b110,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};  // BLTU C=0
    tbl[9]  = '{1'b1,1'b1,3'b110,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};  // BLTU C=1
    tbl[10] = '{1'b1,1'b1,3'b111,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};  // BGEU C=0
    tbl[11] = '{1'b1,1'b1,3'b111,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};  // BGEU C=1
    tbl[12] = '{1'b1,1'b1,3'b010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};  // illegal 010
    tbl[13] = '{1'b1,1'b1,3'b011,1'b1,1'b0,1'b1,1'b0,1'b1,1'b0};  // illegal 011
    tbl[14] = '{1'b0,1'b1,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0};  // !ex_valid
    tbl[15] = '{1'b1,1'b0,3'b001,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0};  // non-branch

    rst_n = 1'b0;
    model_reset();
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h40);
    #12;
    chk("reset_flush_q", 32'(bus.flush_q), 32'd0);
    chk("reset_pred_40", 32'(bus.if_pred_taken), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // First taken BEQ at 0x40 flips its prediction one cycle later.
    idle("lookup40", 32'h40);
    apply("beq40", 1'b1, 1'b1, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h40, 1'b1);
    idle("after40", 32'h40);
    chk("after40_pred_is_1", 32'(bus.if_pred_taken), 32'd1);

    for (int i = 0; i < 16; i++) begin
      apply($sformatf("vec%0d", i), tbl[i].v, tbl[i].br, tbl[i].f3, tbl[i].z, tbl[i].o,
            tbl[i].c, tbl[i].n, tbl[i].pt, 32'h100 + 32'(i * 4), 32'h100 + 32'(i * 4), tbl[i].et);
    end

    // Saturation at 0x80: up to 11, one step down, then down to 00 with no wrap.
    for (int i = 0; i < 5; i++)
      apply("sat_up", 1'b1, 1'b1, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80, 1'b1);
    apply("sat_dn1", 1'b1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h80, 1'b0);
    for (int i = 0; i < 5; i++)
      apply("sat_dn", 1'b1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h80, 1'b0);
    apply("sat_up1", 1'b1, 1'b1, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h80, 1'b1);
    idle("sat_end", 32'h80);

    // Aliasing: 0x04 and 0x44 share an entry; same-cycle lookup sees the old value.
    apply("alias_w", 1'b1, 1'b1, BGEU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h04, 1'b1);
    apply("alias_w2", 1'b1, 1'b1, BGEU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h04, 32'h44, 1'b1);
    idle("alias_r", 32'h44);

    // Illegal funct3 leaves the counter alone.
    apply("ill011", 1'b1, 1'b1, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h48, 32'h48, 1'b0);
    idle("ill_after", 32'h48);

    // Async reset in the middle of a training cycle.
    apply("rs_mis", 1'b1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hC0, 32'hC0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, BEQ, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'hC0);
    #1;
    chk("rs_flush_before", 32'(bus.flush_q), 32'(prev_mis));
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rs_flush_async", 32'(bus.flush_q), 32'd0);
    chk("rs_pred_async", 32'(bus.if_pred_taken), 32'd0);
    chk("rs_taken_comb", 32'(bus.ex_taken), 32'd0);
`ifdef BPU_STATS_EN
    chk("rs_stat_br", bus.stat_branches, 32'd0);
    chk("rs_stat_mis", bus.stat_mispred, 32'd0);
    chk("rs_stat_ill", 32'(bus.stat_illegal), 32'd0);
`endif
    @(negedge clk);
    drive(1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hC0);
    rst_n = 1'b1;
    apply("rs_up", 1'b1, 1'b1, BEQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'hC0, 32'hC0, 1'b1);
    idle("rs_after", 32'hC0);

    // Randomized run: flags derived from real operand pairs, outcome from the comparison itself.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] a, b, d, pc, ifpc;
      logic [2:0]  f3;
      logic        z, o, c, n, v, br, cond, pt;
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
      d  = a - b;
      z  = (a == b);
      n  = d[31];
      c  = (a >= b);
      o  = (a[31] != b[31]) && (d[31] != a[31]);
      f3 = 3'($urandom_range(0, 7));
      case (f3)
        3'b000:  cond = (a == b);
        3'b001:  cond = (a != b);
        3'b100:  cond = ($signed(a) < $signed(b));
        3'b101:  cond = !($signed(a) < $signed(b));
        3'b110:  cond = (a < b);
        3'b111:  cond = !(a < b);
        default: cond = 1'b0;
      endcase
      v    = ($urandom_range(0, 7) != 0);
      br   = ($urandom_range(0, 5) != 0);
      pt   = 1'($urandom_range(0, 1));
      pc   = {$urandom_range(0, 255) == 0 ? 26'h3ff_ffff : 26'($urandom), 4'($urandom_range(0, 15)), 2'($urandom)};
      ifpc = ($urandom_range(0, 1) == 1) ? pc : {26'($urandom), 4'($urandom_range(0, 15)), 2'($urandom)};
      apply("rnd", v, br, f3, z, o, c, n, pt, pc, ifpc, (v && br) ? cond : 1'b0);
    end
    idle("rnd_end", 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Next-generation branch unit. Resolves conditional branches from ALU flags and also predicts them with a parametrised branch history table (BHT) of saturating counters.
- Prediction side is read in IF from the fetch PC.
- Resolution side sits in EX. It computes the actual outcome from funct3 and flags, compares it with the prediction carried down the pipe, raises mispredict/redirect, and trains the BHT.

Parameters:
- PC_W, 32, PC width in bits
- BHT_ENTRIES, 16, number of BHT counters; power of two, 2..256
- CTR_W, 2, saturating counter width in bits; 1..4

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- if_pc  in  PC_W  fetch PC for lookup
- if_pred_taken  out  1  prediction for if_pc (combinational read)
- ex_valid  in  1  EX stage holds a valid instruction
- ex_branch  in  1  EX instruction is a conditional branch
- ex_pc  in  PC_W  PC of EX instruction
- ex_b_control  in  3  branch funct3
- ex_zflag, ex_oflag, ex_cflag, ex_nflag  in  1 each  ALU flags from rs1-rs2
- ex_pred_taken  in  1  prediction made for this instruction in IF, carried down the pipe
- ex_taken  out  1  actual branch outcome
- mispredict  out  1  combinational redirect request
- flush_q  out  1  registered copy of mispredict, one-cycle pulse
- illegal_bcond  out  1  ex_branch with funct3 010/011

Behaviour:
- Index: idx = pc[log2(BHT_ENTRIES)+1 : 2]. Low two PC bits are ignored.
- Prediction: if_pred_taken = MSB of bht[idx(if_pc)].
- Outcome decode, only when ex_valid & ex_branch; otherwise ex_taken = 0:
  - 000 BEQ: Z
  - 001 BNE: !Z
  - 100 BLT: N != O
  - 101 BGE: N == O
  - 110 BLTU: !C
  - 111 BGEU: C
  - 010/011: ex_taken = 0 and illegal_bcond = 1
- mispredict = ex_valid & ex_branch & !illegal_bcond & (ex_taken != ex_pred_taken).
- flush_q <= mispredict on every clock.
- Training, on a rising edge when ex_valid & ex_branch & !illegal_bcond:
  - bht[idx(ex_pc)] increments if ex_taken, else decrements.
  - Counter saturates at all-ones and at zero; no wrap-around.
- No training on an illegal funct3, on !ex_valid, or on a non-branch.
- Same-cycle read and write to the same index: the IF read returns the pre-update value. No write-to-read bypass.
- Reset, asserted at any time including mid-training:
  - All counters are set to weakly-not-taken: MSB 0, all other bits 1 (binary 01 for CTR_W=2). For CTR_W=1 this is 0.
  - flush_q = 0.
  - Combinational outputs follow their inputs.
  - A write coinciding with rst_n low is discarded.
- Latency:
  - Prediction is 0 cycles (combinational).
  - Outcome and mispredict are 0 cycles.
  - Table update is visible to a lookup on the next cycle.
  - flush_q lags mispredict by 1 cycle.

Optional Feature:
- Macro: BPU_STATS_EN.
- When defined, the block adds three outputs:
  - stat_branches (32-bit): counts trained branches.
  - stat_mispred (32-bit): counts mispredict cycles.
  - stat_illegal (16-bit): counts illegal_bcond cycles.
- All three counters reset to 0 and wrap modulo 2^width.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package `bpu_pkg` holds:
  - funct3 localparams BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - The weakly-not-taken reset encoding function.
  - The index-width function clog2(BHT_ENTRIES).
- One natural sub-module: `sat_counter`, parametrised by CTR_W, with inc/dec/en inputs and saturation logic. The BHT instantiates it once per entry via generate.

Test Plan:
- Reset then lookup if_pc=0x40 -> if_pred_taken=0. After one taken BEQ (Z=1, ex_pred_taken=0) at ex_pc=0x40: ex_taken=1, mispredict=1, flush_q=1 the next cycle, and the next lookup at 0x40 gives 1.
- Condition sweep, all six funct3 codes:
  - BLT with N=1,O=0 -> ex_taken=1.
  - BGE with N=1,O=1 -> 1.
  - BLTU with C=0 -> 1.
  - BGEU with C=0 -> 0.
  - BNE with Z=1 -> 0.
  - ex_valid=0 -> ex_taken=0 in all cases.
- Saturation, CTR_W=2:
  - Five taken trainings at 0x80 -> counter 11, prediction 1.
  - Then one not-taken -> 10, prediction still 1.
  - Then five not-taken -> 00, with no wrap to 11.
- Aliasing, BHT_ENTRIES=16: training at 0x04 changes the prediction for 0x44. Same-cycle lookup and train on 0x04 returns the old value, and the new value appears next cycle.
- Illegal funct3 011 with ex_branch=1 -> illegal_bcond=1, ex_taken=0, mispredict=0, counter unchanged. With BPU_STATS_EN, stat_illegal increments by 1.
- rst_n pulled low asynchronously mid-cycle during a training write -> counters return to 01, flush_q=0 immediately with no clock edge needed, and stats clear.
